// File: rtl/game2048_pkg.sv
// rtl/game2048_pkg.sv - shared state, direction and LFSR definitions for the 2048 core
package game2048_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SLIDE = 3'd3,
        ST_SPAWN = 3'd4,
        ST_CHECK = 3'd5,
        ST_WIN   = 3'd6,
        ST_LOSE  = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/game2048_line_merge.sv
// rtl/game2048_line_merge.sv - combinational compact/merge of one board line
module game2048_line_merge #(
    parameter int N     = 4,
    parameter int EXP_W = 4
) (
    input  logic [N-1:0][EXP_W-1:0] line_in,
    input  logic                    reverse,
    output logic [N-1:0][EXP_W-1:0] line_out,
    output logic                    moved,
    output logic [31:0]             score_delta
);

    localparam logic [EXP_W-1:0] MAX_EXP = '1;

    logic [N-1:0][EXP_W-1:0] ordered;
    logic [N-1:0][EXP_W-1:0] merged;
    logic [N:0][EXP_W-1:0]   compacted;
    int                      wr;
    logic                    skip;

    always_comb begin
        ordered     = '0;
        merged      = '0;
        compacted   = '0;
        line_out    = '0;
        score_delta = '0;
        wr          = 0;
        skip        = 1'b0;

        // Work with the leading edge at index 0, then flip back at the end.
        for (int k = 0; k < N; k++)
            ordered[k] = reverse ? line_in[N-1-k] : line_in[k];

        for (int k = 0; k < N; k++) begin
            if (ordered[k] != '0) begin
                compacted[wr] = ordered[k];
                wr = wr + 1;
            end
        end

        // compacted[N] is always zero, so the pair test never merges past the end.
        wr = 0;
        for (int k = 0; k < N; k++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (compacted[k] != '0) begin
                if (compacted[k] == compacted[k+1]) begin
                    merged[wr]  = (compacted[k] == MAX_EXP) ? MAX_EXP : compacted[k] + EXP_W'(1);
                    score_delta = score_delta + (32'd1 << ({1'b0, compacted[k]} + (EXP_W+1)'(1)));
                    skip        = 1'b1;
                end else begin
                    merged[wr] = compacted[k];
                end
                wr = wr + 1;
            end
        end

        for (int k = 0; k < N; k++)
            line_out[k] = reverse ? merged[N-1-k] : merged[k];

        moved = (line_out != line_in);
    end

endmodule

// File: rtl/game2048_core.sv
// rtl/game2048_core.sv - 2048 game engine: board storage, move sequencing, spawn and end-of-game check
module game2048_core
    import game2048_pkg::*;
#(
    parameter int          N       = 4,
    parameter int          EXP_W   = 4,
    parameter int          WIN_EXP = 11,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Dir_valid,
    input  logic [1:0]           Dir,
    input  logic                 Ld_en,
    input  logic [$clog2(N)-1:0] Ld_row,
    input  logic [$clog2(N)-1:0] Ld_col,
    input  logic [EXP_W-1:0]     Ld_data,
    input  logic [$clog2(N)-1:0] Rd_row,
    input  logic [$clog2(N)-1:0] Rd_col,
    output logic [EXP_W-1:0]     Rd_data,
    output logic                 Ready,
    output logic [2:0]           State,
    output logic [31:0]          Score,
    output logic                 Win,
    output logic                 Lose
);

    localparam int              IW        = $clog2(N);
    localparam int              CELLS     = N * N;
    localparam int              CW        = $clog2(CELLS);
    localparam logic [CW-1:0]   LAST_CELL = CW'(CELLS - 1);
    localparam logic [IW-1:0]   LAST_LINE = IW'(N - 1);

    state_e                  state, next_state;
    logic [EXP_W-1:0]        board [N][N];
    logic [31:0]             score;
    logic [15:0]             lfsr;
    dir_e                    dir_q;
    logic [IW-1:0]           line_idx;
    logic                    moved_acc;
    logic [CW-1:0]           spawn_idx, spawn_cnt, chk_idx;
    logic                    init_mode, init_second;
    logic                    win_acc, empty_acc, pair_acc;

    logic                    vert, rev;
    logic [N-1:0][EXP_W-1:0] line_in, line_out;
    logic                    line_moved;
    logic [31:0]             line_score;
    logic [IW-1:0]           sp_row, sp_col, ck_row, ck_col;
    logic                    sp_empty;
    logic [CW-1:0]           sp_start;
    logic [EXP_W-1:0]        spawn_val, ck_cell;
    logic                    ck_win, ck_empty, ck_pair;
    logic                    slide_last, spawn_done, chk_last, spawn_enter;

    assign Rd_data = board[Rd_row][Rd_col];
    assign Ready   = (state == ST_WAIT);
    assign Win     = (state == ST_WIN);
    assign Lose    = (state == ST_LOSE);
    assign State   = state;
    assign Score   = score;

    always_comb begin
        vert = (dir_q == DIR_UP) || (dir_q == DIR_DOWN);
        rev  = (dir_q == DIR_DOWN) || (dir_q == DIR_RIGHT);
        for (int k = 0; k < N; k++)
            line_in[k] = vert ? board[k][line_idx] : board[line_idx][k];
    end

    game2048_line_merge #(.N(N), .EXP_W(EXP_W)) u_line_merge (
        .line_in     (line_in),
        .reverse     (rev),
        .line_out    (line_out),
        .moved       (line_moved),
        .score_delta (line_score)
    );

    always_comb begin
        sp_row    = IW'(spawn_idx / CW'(N));
        sp_col    = IW'(spawn_idx % CW'(N));
        sp_empty  = (board[sp_row][sp_col] == '0);
        sp_start  = CW'(lfsr % 16'(CELLS));
        spawn_val = (lfsr[15:12] == 4'd0) ? EXP_W'(2) : EXP_W'(1);

        ck_row   = IW'(chk_idx / CW'(N));
        ck_col   = IW'(chk_idx % CW'(N));
        ck_cell  = board[ck_row][ck_col];
        ck_win   = (ck_cell >= EXP_W'(WIN_EXP));
        ck_empty = (ck_cell == '0);
        ck_pair  = ((ck_col != LAST_LINE) && (board[ck_row][ck_col + IW'(1)] == ck_cell)) ||
                   ((ck_row != LAST_LINE) && (board[ck_row + IW'(1)][ck_col] == ck_cell));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        slide_last = (line_idx == LAST_LINE);
        spawn_done = sp_empty || (spawn_cnt == LAST_CELL);
        chk_last   = (chk_idx == LAST_CELL);
        case (state)
            ST_IDLE:  if (Start) next_state = ST_INIT;
            ST_INIT:  next_state = ST_SPAWN;
            ST_WAIT: begin
                if (Start)          next_state = ST_INIT;
                else if (Dir_valid) next_state = ST_SLIDE;
            end
            ST_SLIDE: if (slide_last) next_state = (moved_acc || line_moved) ? ST_SPAWN : ST_CHECK;
            ST_SPAWN: begin
                // INIT runs two spawns back to back and skips the end-of-game check.
                if (spawn_done) begin
                    if (!init_mode)       next_state = ST_CHECK;
                    else if (init_second) next_state = ST_WAIT;
                end
            end
            ST_CHECK: begin
                if (chk_last) begin
                    if (win_acc || ck_win)                                    next_state = ST_WIN;
                    else if (!(empty_acc || ck_empty) && !(pair_acc || ck_pair)) next_state = ST_LOSE;
                    else                                                      next_state = ST_WAIT;
                end
            end
            ST_WIN, ST_LOSE: if (Start) next_state = ST_INIT;
            default: next_state = ST_IDLE;
        endcase
        spawn_enter = (next_state == ST_SPAWN) && ((state != ST_SPAWN) || spawn_done);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    board[r][c] <= '0;
            score       <= '0;
            lfsr        <= SEED;
            dir_q       <= DIR_UP;
            line_idx    <= '0;
            moved_acc   <= 1'b0;
            spawn_idx   <= '0;
            spawn_cnt   <= '0;
            chk_idx     <= '0;
            init_mode   <= 1'b0;
            init_second <= 1'b0;
            win_acc     <= 1'b0;
            empty_acc   <= 1'b0;
            pair_acc    <= 1'b0;
        end else begin
            lfsr <= lfsr_next(lfsr);
            case (state)
                ST_IDLE: if (Ld_en) board[Ld_row][Ld_col] <= Ld_data;
                ST_WAIT: begin
                    if (Ld_en) board[Ld_row][Ld_col] <= Ld_data;
                    if (Dir_valid) dir_q <= dir_e'(Dir);
                end
                ST_INIT: begin
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++)
                            board[r][c] <= '0;
                    score       <= '0;
                    init_mode   <= 1'b1;
                    init_second <= 1'b0;
                end
                ST_SLIDE: begin
                    for (int k = 0; k < N; k++) begin
                        if (vert) board[k][line_idx] <= line_out[k];
                        else      board[line_idx][k] <= line_out[k];
                    end
                    score     <= score + line_score;
                    line_idx  <= line_idx + IW'(1);
                    moved_acc <= moved_acc | line_moved;
                end
                ST_SPAWN: begin
                    if (sp_empty) board[sp_row][sp_col] <= spawn_val;
                    spawn_idx <= (spawn_idx == LAST_CELL) ? '0 : spawn_idx + CW'(1);
                    spawn_cnt <= spawn_cnt + CW'(1);
                    if (spawn_done && init_mode) begin
                        if (init_second) init_mode   <= 1'b0;
                        else             init_second <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    chk_idx   <= chk_idx + CW'(1);
                    win_acc   <= win_acc | ck_win;
                    empty_acc <= empty_acc | ck_empty;
                    pair_acc  <= pair_acc | ck_pair;
                end
                default: ;
            endcase
            if (spawn_enter) begin
                spawn_idx <= sp_start;
                spawn_cnt <= '0;
            end
            if (state != ST_SLIDE) begin
                line_idx  <= '0;
                moved_acc <= 1'b0;
            end
            if (state != ST_CHECK) begin
                chk_idx   <= '0;
                win_acc   <= 1'b0;
                empty_acc <= 1'b0;
                pair_acc  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_game2048_core.sv
// tb/tb_game2048_core.sv - scoreboard bench for game2048_core with directed move scenarios
module tb_game2048_core;
    import game2048_pkg::*;

    logic        Clk, Reset, Start, Dir_valid, Ld_en;
    logic [1:0]  Dir, Ld_row, Ld_col, Rd_row, Rd_col;
    logic [3:0]  Ld_data, Rd_data;
    logic        Ready, Win, Lose;
    logic [2:0]  State;
    logic [31:0] Score;

    game2048_core #(.N(4), .EXP_W(4), .WIN_EXP(11), .SEED(16'hACE1)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Dir_valid(Dir_valid), .Dir(Dir),
        .Ld_en(Ld_en), .Ld_row(Ld_row), .Ld_col(Ld_col), .Ld_data(Ld_data),
        .Rd_row(Rd_row), .Rd_col(Rd_col), .Rd_data(Rd_data),
        .Ready(Ready), .State(State), .Score(Score), .Win(Win), .Lose(Lose)
    );

    initial Clk = 1'b0;
    always #50 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic [31:0] score;
        logic [63:0] board;
        int          new_cells;
        int          lat_min;
        int          lat_max;
    } exp_t;

    exp_t q[$];
    int   checks, errors;
    int   cyc, t0;
    int   snap_req, snap_seen;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [15:0] row(input logic [3:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [63:0] brd(input logic [15:0] r0, r1, r2, r3);
        return {r3, r2, r1, r0};
    endfunction

    function automatic logic is_rest(input logic [2:0] s);
        return (s == 3'(ST_WAIT)) || (s == 3'(ST_WIN)) || (s == 3'(ST_LOSE));
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, req);
        end
    endtask

    initial begin : monitor
        exp_t        e;
        logic [63:0] act;
        logic [2:0]  prev_state, st_s;
        logic [31:0] sc_s;
        logic [2:0]  flags_s, flags_e;
        logic        trig;
        int          mism, newc, lat, wait_cnt;
        prev_state = 3'(ST_IDLE);
        wait_cnt   = 0;
        forever begin
            @(negedge Clk);
            st_s    = State;
            sc_s    = Score;
            flags_s = {Ready, Win, Lose};
            trig    = is_rest(st_s) && !is_rest(prev_state);
            if (st_s == 3'(ST_SLIDE) && prev_state == 3'(ST_WAIT)) t0 = cyc;
            if (snap_req != snap_seen) begin
                trig = 1'b1;
                snap_seen++;
            end
            prev_state = st_s;
            if (trig && q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response state %0d required no response", st_s);
            end else if (trig) begin
                e = q[0];
                for (int i = 0; i < 16; i++) begin
                    Rd_row = 2'(i / 4);
                    Rd_col = 2'(i % 4);
                    #1;
                    act[4*i +: 4] = Rd_data;
                end
                mism = 0;
                newc = 0;
                for (int i = 0; i < 16; i++) begin
                    if (e.board[4*i +: 4] != 4'd0) begin
                        if (act[4*i +: 4] != e.board[4*i +: 4]) mism++;
                    end else if (act[4*i +: 4] != 4'd0) begin
                        if (act[4*i +: 4] == 4'd1 || act[4*i +: 4] == 4'd2) newc++;
                        else mism++;
                    end
                end
                flags_e = {e.st == 3'(ST_WAIT), e.st == 3'(ST_WIN), e.st == 3'(ST_LOSE)};
                check({e.name, "_state"}, 64'(st_s), 64'(e.st));
                check({e.name, "_score"}, 64'(sc_s), 64'(e.score));
                check({e.name, "_flags_rdy_win_lose"}, 64'(flags_s), 64'(flags_e));
                checks++;
                if (mism != 0) begin
                    errors++;
                    $display("FAIL %s_board actual %016h required %016h (%0d cells differ)",
                             e.name, act, e.board, mism);
                end
                check({e.name, "_new_cells"}, 64'(newc), 64'(e.new_cells));
                if (e.lat_max != 0) begin
                    lat = cyc - t0 + 1;
                    checks++;
                    if (lat < e.lat_min || lat > e.lat_max) begin
                        errors++;
                        $display("FAIL %s_latency actual %0d required %0d..%0d",
                                 e.name, lat, e.lat_min, e.lat_max);
                    end
                end
                e = q.pop_front();
                wait_cnt = 0;
            end else if (q.size() != 0) begin
                wait_cnt++;
                if (wait_cnt > 400) begin
                    checks++;
                    errors++;
                    $display("FAIL %s_timeout actual no response required response", q[0].name);
                    e = q.pop_front();
                    wait_cnt = 0;
                end
            end
        end
    end

    task automatic expect_resp(input string nm, input logic [2:0] st, input logic [31:0] sc,
                               input logic [63:0] b, input int nc, input int lmin, input int lmax);
        exp_t e;
        e.name = nm; e.st = st; e.score = sc; e.board = b;
        e.new_cells = nc; e.lat_min = lmin; e.lat_max = lmax;
        q.push_back(e);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 3000) begin
            @(negedge Clk);
            k++;
        end
        if (q.size() != 0) begin
            $display("FAIL drain_timeout actual %0d pending required 0", q.size());
            $fatal(1, "bench stalled");
        end
        @(negedge Clk);
    endtask

    task automatic pulse_start();
        @(negedge Clk) Start = 1'b1;
        @(negedge Clk) Start = 1'b0;
    endtask

    task automatic move(input logic [1:0] d);
        @(negedge Clk);
        Dir = d;
        Dir_valid = 1'b1;
        @(negedge Clk) Dir_valid = 1'b0;
    endtask

    task automatic load(input logic [63:0] b);
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            Ld_en   = 1'b1;
            Ld_row  = 2'(i / 4);
            Ld_col  = 2'(i % 4);
            Ld_data = b[4*i +: 4];
        end
        @(negedge Clk) Ld_en = 1'b0;
    endtask

    initial begin : stim
        logic [63:0] rest, cb;
        Reset = 1'b1; Start = 1'b0; Dir_valid = 1'b0; Dir = 2'd0;
        Ld_en = 1'b0; Ld_row = 2'd0; Ld_col = 2'd0; Ld_data = 4'd0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        rest = brd(16'h0, row(3, 4, 5, 6), row(4, 5, 6, 7), row(5, 6, 7, 8));

        expect_resp("reset", 3'(ST_IDLE), 0, 64'h0, 0, 0, 0);
        snap_req++;
        drain();

        move(2'(DIR_LEFT));
        expect_resp("dir_in_idle", 3'(ST_IDLE), 0, 64'h0, 0, 0, 0);
        snap_req++;
        drain();

        expect_resp("start", 3'(ST_WAIT), 0, 64'h0, 2, 0, 0);
        pulse_start();
        drain();

        load(rest | brd(row(1, 1, 2, 2), 0, 0, 0));
        expect_resp("merge_pairs", 3'(ST_WAIT), 12, rest | brd(row(2, 3, 0, 0), 0, 0, 0), 1, 22, 37);
        move(2'(DIR_LEFT));
        drain();

        load(rest | brd(row(2, 2, 2, 2), 0, 0, 0));
        expect_resp("no_cascade", 3'(ST_WAIT), 28, rest | brd(row(3, 3, 0, 0), 0, 0, 0), 1, 22, 37);
        move(2'(DIR_LEFT));
        drain();

        load(rest | brd(row(1, 1, 1, 0), 0, 0, 0));
        expect_resp("odd_triple", 3'(ST_WAIT), 32, rest | brd(row(2, 1, 0, 0), 0, 0, 0), 1, 22, 37);
        move(2'(DIR_LEFT));
        drain();

        load(brd(row(1, 0, 0, 0), row(2, 0, 0, 0), row(3, 0, 0, 0), row(4, 0, 0, 0)));
        expect_resp("unmoved", 3'(ST_WAIT), 32,
                    brd(row(1, 0, 0, 0), row(2, 0, 0, 0), row(3, 0, 0, 0), row(4, 0, 0, 0)), 0, 21, 21);
        move(2'(DIR_LEFT));
        drain();

        load(brd(row(10, 10, 0, 0), 0, 0, 0));
        expect_resp("win", 3'(ST_WIN), 2080, brd(row(11, 0, 0, 0), 0, 0, 0), 1, 22, 37);
        move(2'(DIR_LEFT));
        drain();

        expect_resp("restart_from_win", 3'(ST_WAIT), 0, 64'h0, 2, 0, 0);
        pulse_start();
        drain();

        cb = 64'h0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                cb[4*(r*4 + c) +: 4] = ((r + c) % 2 == 1) ? 4'd2 : 4'd1;
        load(cb);
        expect_resp("lose", 3'(ST_LOSE), 0, cb, 0, 21, 21);
        move(2'(DIR_UP));
        drain();

        expect_resp("restart_from_lose", 3'(ST_WAIT), 0, 64'h0, 2, 0, 0);
        pulse_start();
        drain();

        load(rest | brd(row(1, 1, 2, 2), 0, 0, 0));
        @(negedge Clk);
        Dir = 2'(DIR_LEFT);
        Dir_valid = 1'b1;
        @(negedge Clk) Dir_valid = 1'b0;
        @(posedge Clk);
        #10 Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk) Reset = 1'b0;
        expect_resp("reset_mid_slide", 3'(ST_IDLE), 0, 64'h0, 0, 0, 0);
        snap_req++;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game2048_core.md
GAME2048_CORE -- requirements
Module: game2048_core

Interface
REQ-001 SHALL take these parameters:
- N, 4, board dimension (N x N cells, N >= 2).
- EXP_W, 4, tile exponent width; cell value e encodes tile 2^e, and 0 means empty.
- WIN_EXP, 11, exponent that wins the game (2048).
- SEED, 16'hACE1, nonzero LFSR seed.

REQ-002 SHALL have these ports:
- Clk  in  1  clock.
- Reset  in  1  reset; asynchronous, active-high.
- Start  in  1  start or restart the game.
- Dir_valid  in  1  move request strobe.
- Dir  in  2  move direction: 0 up, 1 down, 2 left, 3 right.
- Ld_en  in  1  bench/host cell write.
- Ld_row  in  clog2(N)  write row.
- Ld_col  in  clog2(N)  write column.
- Ld_data  in  EXP_W  write value.
- Rd_row  in  clog2(N)  read row.
- Rd_col  in  clog2(N)  read column.
- Rd_data  out  EXP_W  combinational cell read.
- Ready  out  1  high only in WAIT.
- State  out  3  current state code.
- Score  out  32  accumulated score.
- Win  out  1  high in WIN.
- Lose  out  1  high in LOSE.

Function
REQ-003 SHALL use states IDLE, INIT, WAIT, SLIDE, SPAWN, CHECK, WIN, LOSE.
REQ-004 SHALL advance the 16-bit Fibonacci LFSR (taps 16,14,13,11) every cycle, in all states.
REQ-005 In IDLE, Start SHALL go to INIT.
REQ-006 INIT SHALL clear the board and Score in one cycle, then perform two SPAWNs, then go to WAIT; no CHECK is performed.
REQ-007 In WAIT, Start SHALL take priority over Dir_valid and go to INIT.
REQ-008 In WAIT, Dir_valid SHALL latch Dir and go to SLIDE.
REQ-009 Dir_valid SHALL be ignored in every state other than WAIT.
REQ-010 Ld_en SHALL write the cell only in IDLE or WAIT; it is ignored elsewhere.
REQ-011 SLIDE SHALL process one line per cycle, for exactly N cycles:
- Line order: rows for left/right, columns for up/down.
- Leading edge: index 0 for up/left, index N-1 for down/right.
REQ-012 Line rule, applied in order:
- compact nonzero cells toward the leading edge;
- scan from the leading edge and merge each equal adjacent pair into e+1;
- a result cell SHALL NOT merge again in the same move;
- refill the tail with 0.
REQ-013 Each merge into e+1 SHALL add 2^(e+1) to Score, modulo 2^32.
REQ-014 A merge at e = 2^EXP_W-1 SHALL saturate at 2^EXP_W-1.
REQ-015 If any cell changed during SLIDE, the next state SHALL be SPAWN; otherwise it SHALL be CHECK, with no spawn.
REQ-016 SPAWN start point and scan:
- start index = LFSR mod N*N, sampled on entry;
- scan one cell per cycle, wrapping, until the first empty cell is found;
- at most N*N cycles.
REQ-017 SPAWN SHALL write 2 (tile 4) if LFSR[15:12] == 0 at the write cycle, else 1 (tile 2).
REQ-018 If SPAWN finds no empty cell, it SHALL write nothing.
REQ-019 CHECK SHALL scan all cells in N*N cycles, then transition:
- any cell >= WIN_EXP -> WIN;
- else, no empty cell and no horizontally or vertically adjacent equal pair -> LOSE;
- else -> WAIT.
- Win takes priority over Lose.
REQ-020 WIN and LOSE SHALL hold the board and Score; Start SHALL go to INIT.
REQ-021 Latency from Dir_valid accepted to Ready SHALL be 1 + N + (spawn scan cycles, 0 if unmoved) + N*N cycles.
REQ-022 Rd_data SHALL reflect the registered board at all times, including mid-move.

Reset
REQ-023 Reset SHALL, asynchronously:
- set State=IDLE, all cells=0, Score=0, LFSR=SEED;
- drive Ready=0, Win=0, Lose=0.
REQ-024 Reset asserted during SLIDE, SPAWN or CHECK SHALL abandon the move; no partial update survives.

Structure
REQ-025 Package game2048_pkg SHALL hold:
- the state encoding;
- the Dir codes;
- the LFSR tap constant.
REQ-026 Sub-module game2048_line_merge SHALL be purely combinational:
- takes N cells and a reverse flag;
- returns the merged line, a moved flag and the score delta;
- instantiated once.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset, then Start -> exactly 2 nonzero cells, each 1 or 2; Score=0; Ready high.
- Load row0=[1,1,2,2] plus a distinct-valued rest, Dir=left -> row0=[2,3,0,0] before spawn; Score +12; exactly one new cell.
- Load row0=[2,2,2,2] -> left gives [3,3,0,0], no cascade; load [1,1,1,0] -> left gives [2,1,0,0].
- Tiles only in column 0, Dir=left -> board unchanged; no spawn; Score unchanged; Ready after 1+N+N*N cycles.
- Load row0=[10,10,0,0], Dir=left -> cell(0,0)=11; Win=1; State=WIN; Start -> INIT.
- Full checkerboard 1/2, any Dir -> Lose=1. Separately, Reset pulsed mid-SLIDE -> State=IDLE and all cells 0.
